// File: rtl/alu_sequencer.sv
// Command/response sequencer for a 16-bit combinational ALU (ADD/SHL1/SHR1/NAND).
// Adds N-bit shifts and a shift-and-add multiply by iterating the ALU primitives.
module alu_sequencer #(
    parameter int WIDTH    = 16,
    parameter int MUL_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [1:0]       alu_fs,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, ITER, RESP} state_e;
    typedef enum logic [2:0] {
        OP_ADD, OP_SHL1, OP_SHR1, OP_NAND, OP_SHLN, OP_SHRN, OP_MUL, OP_ILL
    } op_e;

    localparam int CNT_W = $clog2(2 * MUL_BITS);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(2 * MUL_BITS - 1);

    state_e           state, next;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;      // operand A; shift working reg; multiplicand for MUL
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-2:0] bit_idx;
    logic             last;
    logic             cmd_iter;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    // MUL alternates add (even cnt) and multiplicand-shift (odd cnt) steps
    assign bit_idx   = cnt[CNT_W-1:1];
    assign cmd_iter  = (cmd_op == OP_MUL) ||
                       (((cmd_op == OP_SHLN) || (cmd_op == OP_SHRN)) && (cmd_b[3:0] != 4'd0));

    always_comb begin
        next     = state;
        alu_fs   = '0;
        alu_a    = '0;
        alu_b    = '0;
        last_cnt = (op_r == OP_MUL) ? MUL_LAST : CNT_W'(b_r[3:0] - 4'd1);
        last     = (cnt == last_cnt);
        case (state)
            IDLE: if (cmd_valid) next = cmd_iter ? ITER : EXEC;
            EXEC: begin
                next = RESP;
                if (op_r <= OP_NAND) begin
                    alu_fs = op_r[1:0];
                    alu_a  = a_r;
                    alu_b  = b_r;
                end
            end
            ITER: begin
                if (last) next = RESP;
                case (op_r)
                    OP_SHLN: begin
                        alu_fs = 2'd1;
                        alu_a  = a_r;
                    end
                    OP_SHRN: begin
                        alu_fs = 2'd2;
                        alu_a  = a_r;
                    end
                    OP_MUL: begin
                        if (!cnt[0]) begin
                            if (b_r[bit_idx]) begin
                                alu_a = acc;
                                alu_b = a_r;
                            end
                        end else begin
                            alu_fs = 2'd1;
                            alu_a  = a_r;
                        end
                    end
                    default: ;
                endcase
            end
            RESP: if (rsp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r <= cmd_op;
                        a_r  <= cmd_a;
                        b_r  <= cmd_b;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                EXEC: begin
                    case (op_r)
                        OP_ADD, OP_SHL1, OP_SHR1, OP_NAND: begin
                            rsp_data <= alu_c;
                            rsp_err  <= 1'b0;
                        end
                        OP_ILL: begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                        default: begin
                            rsp_data <= a_r;
                            rsp_err  <= 1'b0;
                        end
                    endcase
                end
                ITER: begin
                    cnt     <= cnt + CNT_W'(1);
                    rsp_err <= 1'b0;
                    if (op_r == OP_MUL) begin
                        if (!cnt[0]) begin
                            if (b_r[bit_idx]) acc <= alu_c;
                        end else begin
                            a_r <= alu_c;
                        end
                        // final step is a shift, so acc already holds the product
                        if (last) rsp_data <= acc;
                    end else begin
                        a_r <= alu_c;
                        if (last) rsp_data <= alu_c;
                    end
                end
                RESP: if (rsp_ready) rsp_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
